// File: rtl/bus_drvr_fifo_array.sv
// Per-terminal source FIFO array: one first-word-fall-through FIFO per (bus, driver) channel,
// with occupancy, sticky overflow/underflow flags and a per-channel delivery monitor.
module bus_drvr_fifo_array #(
  parameter int bits     = 1,
  parameter int drvrs    = 4,
  parameter int pckg_sz  = 16,
  parameter int depth    = 8,
  parameter int ovf_mode = 0,
  localparam int N  = bits * drvrs,
  localparam int CW = $clog2(depth + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         fifo_wr,
  input  logic [N*pckg_sz-1:0] fifo_wdata,
  output logic [N-1:0]         pndng,
  input  logic [N-1:0]         pop,
  output logic [N*pckg_sz-1:0] D_pop,
  input  logic [N-1:0]         push,
  input  logic [N*pckg_sz-1:0] D_push,
  output logic [N*CW-1:0]      count,
  output logic [N-1:0]         ovf,
  output logic [N-1:0]         udf,
  input  logic                 clr_flags,
  output logic [N*pckg_sz-1:0] last_push,
  output logic [N*16-1:0]      push_cnt
);

  localparam int PW = $clog2(depth);

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    inc_ptr = (p == PW'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar ch = 0; ch < N; ch++) begin : g_ch
    logic [pckg_sz-1:0] mem [depth];
    logic [PW-1:0]      head, tail;
    logic [CW-1:0]      cnt;
    logic               ovf_q, udf_q;
    logic [pckg_sz-1:0] lp_q;
    logic [15:0]        pc_q;
    logic               full, empty, do_pop, wr_ok, adv_head, ovf_set, udf_set;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(depth));
    assign do_pop   = pop[ch] && !empty;
    // A write into a full FIFO lands only if a pop frees a slot or overwrite is enabled.
    assign wr_ok    = fifo_wr[ch] && (!full || do_pop || (ovf_mode != 0));
    assign adv_head = do_pop || (wr_ok && full);
    assign ovf_set  = fifo_wr[ch] && full && !do_pop;
    assign udf_set  = pop[ch] && empty;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        head  <= '0;
        tail  <= '0;
        cnt   <= '0;
        ovf_q <= 1'b0;
        udf_q <= 1'b0;
        lp_q  <= '0;
        pc_q  <= '0;
      end else begin
        if (wr_ok)    tail <= inc_ptr(tail);
        if (adv_head) head <= inc_ptr(head);
        if (wr_ok && !adv_head)      cnt <= cnt + 1'b1;
        else if (!wr_ok && adv_head) cnt <= cnt - 1'b1;
        ovf_q <= ovf_set || (ovf_q && !clr_flags);
        udf_q <= udf_set || (udf_q && !clr_flags);
        if (push[ch]) begin
          lp_q <= D_push[ch*pckg_sz +: pckg_sz];
          pc_q <= pc_q + 16'd1;
        end
      end
    end

    // Storage is intentionally not reset; D_pop masking hides stale entries.
    always_ff @(posedge clk) begin
      if (wr_ok) mem[tail] <= fifo_wdata[ch*pckg_sz +: pckg_sz];
    end

    assign pndng[ch]                     = !empty;
    assign D_pop[ch*pckg_sz +: pckg_sz]  = empty ? '0 : mem[head];
    assign count[ch*CW +: CW]            = cnt;
    assign ovf[ch]                       = ovf_q;
    assign udf[ch]                       = udf_q;
    assign last_push[ch*pckg_sz +: pckg_sz] = lp_q;
    assign push_cnt[ch*16 +: 16]         = pc_q;
  end

endmodule
